shared_counter_sched: RTL and testbench

SHARED_COUNTER_SCHED -- requirements
Module: shared_counter_sched

---
 rtl/shared_counter_sched_pkg.sv | 13 +
 rtl/shared_counter_sched_if.sv | 17 +
 rtl/shared_counter_sched_up_counter_ce.sv | 20 ++
 rtl/shared_counter_sched.sv | 97 +++++++++
 tb/tb_shared_counter_sched.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/shared_counter_sched_pkg.sv
// Shared types and constants for the shared counter scheduler slice.
package counter_sched_pkg;

    localparam int unsigned W_DEFAULT = 4;
    localparam int unsigned NREQ      = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shared_counter_sched_if.sv
// Request/grant/count bundle between requesters (master) and the scheduler (slave).
interface shared_counter_sched_if
    import counter_sched_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
);
    logic [NREQ-1:0] req;
    logic [W-1:0]    len0;
    logic [W-1:0]    len1;
    logic [NREQ-1:0] gnt;
    logic            busy;
    logic [NREQ-1:0] done;
    logic [W-1:0]    count;

    modport master (output req, len0, len1, input gnt, busy, done, count);
    modport slave  (input req, len0, len1, output gnt, busy, done, count);
endinterface

// File: rtl/shared_counter_sched_up_counter_ce.sv
// W-bit up counter: synchronous clear (dominant), count enable, async active-low reset.
module up_counter_ce #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         ce,
    output logic [W-1:0] count
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (ce) begin
            count <= count + W'(1);
        end
    end
endmodule

// File: rtl/shared_counter_sched.sv
// Two-requester scheduler sharing one up counter; define ROUND_ROBIN_EN for
// round-robin arbitration, otherwise requester 0 has fixed priority.
module shared_counter_sched
    import counter_sched_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    shared_counter_sched_if.slave   bus
);
    state_t          state;
    logic            owner;
    logic            win;
    logic [W-1:0]    len_q;
    logic [NREQ-1:0] gnt_q;
    logic [NREQ-1:0] done_q;
    logic            busy_q;
    logic            abandon;
    logic            at_len;
    logic            clr;
    logic            ce;

`ifdef ROUND_ROBIN_EN
    logic ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= 1'b0;
        end else if (state == IDLE && |bus.req) begin
            ptr <= ~win;
        end
    end

    always_comb win = (&bus.req) ? ptr : ~bus.req[0];
`else
    always_comb win = ~bus.req[0];
`endif

    assign abandon = (state == RUN) && !bus.req[owner];
    assign at_len  = (bus.count == len_q);
    // Counter is held at zero everywhere except a live RUN interval, and stalls at len_q.
    assign clr     = (state != RUN) || abandon;
    assign ce      = (state == RUN) && !at_len;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            owner  <= 1'b0;
            len_q  <= '0;
            gnt_q  <= '0;
            done_q <= '0;
            busy_q <= 1'b0;
        end else begin
            done_q <= '0;
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        owner  <= win;
                        len_q  <= win ? bus.len1 : bus.len0;
                        gnt_q  <= win ? 2'b10 : 2'b01;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (abandon) begin
                        gnt_q  <= '0;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else if (at_len) begin
                        done_q <= gnt_q;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    gnt_q  <= '0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    up_counter_ce #(.W(W)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .ce    (ce),
        .count (bus.count)
    );

    assign bus.gnt  = gnt_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_shared_counter_sched.sv
// Directed plus randomized bench for shared_counter_sched against an interval-level model.
module tb_shared_counter_sched;
    import counter_sched_pkg::*;

    localparam int unsigned W = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    shared_counter_sched_if #(.W(W)) bus ();

    shared_counter_sched #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Model: owner index (-1 = free), cycles elapsed since grant, latched length, tie pointer.
    int m_own = -1;
    int m_el  = 0;
    int m_len = 0;
    int m_ptr = 0;
    bit auto_drop = 1'b1;

    function automatic int pick(logic [1:0] r);
`ifdef ROUND_ROBIN_EN
        if (r == 2'b11) return m_ptr;
`endif
        return r[0] ? 0 : 1;
    endfunction

    function automatic logic [1:0] e_gnt();
        if (m_own < 0) return 2'b00;
        return (m_own == 1) ? 2'b10 : 2'b01;
    endfunction

    function automatic logic e_busy();
        return (m_own >= 0);
    endfunction

    function automatic logic [W-1:0] e_count();
        if (m_own < 0) return '0;
        return W'((m_el <= m_len) ? m_el : m_len);
    endfunction

    function automatic logic [1:0] e_done();
        if (m_own >= 0 && m_el == m_len + 1) return e_gnt();
        return 2'b00;
    endfunction

    task automatic model_reset();
        m_own = -1;
        m_el  = 0;
        m_len = 0;
        m_ptr = 0;
    endtask

    // Interval rules: grant from free, run len+1 cycles (count 0..len), one done cycle, one free cycle.
    task automatic model_step();
        int w;
        if (!rst) begin
            model_reset();
        end else if (m_own < 0) begin
            if (bus.req != 2'b00) begin
                w     = pick(bus.req);
                m_own = w;
                m_el  = 0;
                m_len = (w == 1) ? int'(bus.len1) : int'(bus.len0);
                m_ptr = 1 - w;
            end
        end else if (m_el <= m_len && !bus.req[m_own]) begin
            m_own = -1;
        end else begin
            m_el++;
            if (m_el > m_len + 1) m_own = -1;
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(string tag);
        chk({tag, ".gnt"},   32'(bus.gnt),   32'(e_gnt()));
        chk({tag, ".busy"},  32'(bus.busy),  32'(e_busy()));
        chk({tag, ".done"},  32'(bus.done),  32'(e_done()));
        chk({tag, ".count"}, 32'(bus.count), 32'(e_count()));
    endtask

    task automatic cycle(string tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outs(tag);
        if (auto_drop) bus.req = bus.req & ~e_done();
    endtask

    task automatic async_reset(string tag);
        #2 rst = 1'b0;
        #1 model_reset();
        check_outs(tag);
        chk({tag, ".cnt0"}, 32'(bus.count), 32'd0);
        cycle({tag, "_hold"});
        rst = 1'b1;
    endtask

    initial begin
        int dn;
        int cap;
        int ng;
        logic [1:0] prev;
        int gseq[4];

        bus.req  = 2'b00;
        bus.len0 = '0;
        bus.len1 = '0;

        cycle("reset");
        cycle("reset");
        rst = 1'b1;

        // Basic interval, len0=3.
        bus.len0 = 4'd3;
        bus.req  = 2'b01;
        dn = 0;
        for (int i = 0; i < 7; i++) begin
            cycle("r029");
            if (bus.done != 2'b00) dn++;
        end
        chk("r029_done_pulses", 32'(dn), 32'd1);

        // Zero-length interval on requester 1.
        bus.len1 = 4'd0;
        bus.req  = 2'b10;
        dn = 0;
        for (int i = 0; i < 4; i++) begin
            cycle("r031");
            if (bus.done != 2'b00) dn++;
        end
        chk("r031_done_pulses", 32'(dn), 32'd1);

        // Abandon at count 4 of 9.
        bus.len0 = 4'd9;
        bus.req  = 2'b01;
        dn = 0;
        cycle("r032");
        for (int i = 0; i < 12 && e_count() != 4; i++) cycle("r032");
        chk("r032_reached4", 32'(bus.count), 32'd4);
        bus.req = 2'b00;
        cycle("r032_drop");
        chk("r032_gnt0", 32'(bus.gnt), 32'd0);
        chk("r032_cnt0", 32'(bus.count), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cycle("r032_after");
            if (bus.done != 2'b00) dn++;
        end
        chk("r032_no_done", 32'(dn), 32'd0);

        // Length change mid-run is ignored.
        bus.len0 = 4'd3;
        bus.req  = 2'b01;
        cycle("r034");
        cycle("r034");
        bus.len0 = 4'd15;
        cap = -1;
        for (int i = 0; i < 20 && cap < 0; i++) begin
            cycle("r034");
            if (bus.done[0]) cap = int'(bus.count);
        end
        chk("r034_end_count", 32'(cap), 32'd3);
        bus.req = 2'b00;
        cycle("r034_tail");

        // Async reset at count 5 of 12, request held through release.
        bus.len0 = 4'd12;
        bus.req  = 2'b01;
        cycle("r033");
        for (int i = 0; i < 12 && e_count() != 5; i++) cycle("r033");
        chk("r033_at5", 32'(bus.count), 32'd5);
        async_reset("r033_async");
        cycle("r033_restart");
        chk("r033_restart_cnt", 32'(bus.count), 32'd0);
        for (int i = 0; i < 20 && bus.req != 2'b00; i++) cycle("r033_run");
        cycle("r033_tail");

        // Both requesters held from reset.
        rst = 1'b0;
        cycle("r030_rst");
        rst = 1'b1;
        auto_drop = 1'b0;
        bus.len0 = 4'd2;
        bus.len1 = 4'd1;
        bus.req  = 2'b11;
        prev = 2'b00;
        ng = 0;
        for (int i = 0; i < 24; i++) begin
            cycle("r030");
            if (prev == 2'b00 && bus.gnt != 2'b00 && ng < 4) begin
                gseq[ng] = bus.gnt[1] ? 1 : 0;
                ng++;
            end
            prev = bus.gnt;
        end
        chk("r030_ngrants", 32'(ng >= 3), 32'd1);
`ifdef ROUND_ROBIN_EN
        chk("r030_g0", 32'(gseq[0]), 32'd0);
        chk("r030_g1", 32'(gseq[1]), 32'd1);
        chk("r030_g2", 32'(gseq[2]), 32'd0);
`else
        chk("r030_g0", 32'(gseq[0]), 32'd0);
        chk("r030_g1", 32'(gseq[1]), 32'd0);
        chk("r030_g2", 32'(gseq[2]), 32'd0);
`endif
        bus.req = 2'b00;
        auto_drop = 1'b1;
        cycle("r030_tail");
        cycle("r030_tail");

        // Randomized traffic: raises, abandons, length churn, occasional async reset.
        for (int i = 0; i < 800; i++) begin
            for (int r = 0; r < 2; r++) begin
                if (!bus.req[r] && $urandom_range(3) == 0) begin
                    bus.req[r] = 1'b1;
                    if (r == 0) bus.len0 = 4'($urandom_range(15));
                    else        bus.len1 = 4'($urandom_range(15));
                end
            end
            if (m_own >= 0 && $urandom_range(29) == 0) bus.req[m_own] = 1'b0;
            if ($urandom_range(7) == 0) begin
                if ($urandom_range(1) == 0) bus.len0 = 4'($urandom_range(15));
                else                        bus.len1 = 4'($urandom_range(15));
            end
            if ($urandom_range(199) == 0) async_reset("rand_rst");
            cycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
